// File: rtl/crypto_pkg.sv
// crypto_pkg: shared op encodings, FSM states, error bit indices and queue entry layout
package crypto_pkg;
  localparam logic [1:0] OP_HASH = 2'd0;
  localparam logic [1:0] OP_ENC  = 2'd1;
  localparam logic [1:0] OP_DEC  = 2'd2;
  localparam int ERR_OVF = 0;
  localparam int ERR_COL = 1;
  localparam int ERR_TMO = 2;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] index;
  } job_t;
  // Simultaneous requests resolve H > E > D
  function automatic logic [1:0] pick_op(input logic h, input logic e);
    return h ? OP_HASH : e ? OP_ENC : OP_DEC;
  endfunction
endpackage

// File: rtl/job_fifo.sv
// job_fifo: synchronous FIFO of 18-bit {op, index} job entries
//   push_i/pop_i : enqueue / dequeue requests (push while full succeeds only with a pop)
//   data_i/data_o: entry written / head entry
//   full_o       : registered, high while DEPTH entries are held
//   empty_o      : no entries held
//   count_o      : occupancy, $clog2(DEPTH)+1 bits
module job_fifo
  import crypto_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  job_t                   data_i,
  output job_t                   data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, do_push, do_pop;
  job_t          mem_q [DEPTH];
  always_comb begin
    do_pop  = pop_i && cnt_q != '0;
    do_push = push_i && (cnt_q != FULL || do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      wr_q   <= wr_q + AW'(do_push);
      rd_q   <= rd_q + AW'(do_pop);
      cnt_q  <= cnt_d;
      full_q <= cnt_d == FULL;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
  assign data_o  = mem_q[rd_q];
  assign full_o  = full_q;
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/crypto_job_ctrl.sv
// crypto_job_ctrl: queues CPU crypto requests and sequences them through a single engine
//   H_int/E_int/D_int, index : CPU request pulses with job memory index
//   H_done/E_done/D_done     : per-op completion pulses back to the CPU
//   eng_start/eng_op/eng_index, eng_busy/eng_done : engine handshake
//   err_clr, err             : sticky {timeout, collision, overflow} flags and their clear
//   q_full                   : request queue full
module crypto_job_ctrl
  import crypto_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        H_int,
  input  logic        E_int,
  input  logic        D_int,
  input  logic [15:0] index,
  output logic        H_done,
  output logic        E_done,
  output logic        D_done,
  output logic        eng_start,
  output logic [1:0]  eng_op,
  output logic [15:0] eng_index,
  input  logic        eng_busy,
  input  logic        eng_done,
  input  logic        err_clr,
  output logic        q_full,
  output logic [2:0]  err
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   ONE  = (AW+1)'(1);
  state_t        state_q, state_d;
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic          start_q, start_d;
  logic [1:0]    op_q, op_d;
  logic [15:0]   idx_q, idx_d;
  logic [2:0]    done_q, done_d;
  logic [2:0]    err_q, err_d, err_new;
  logic          push, pop, launch, respond, tmo, empty, full;
  logic [AW:0]   count;
  job_t          head, entry;
  always_comb begin
    push  = H_int | E_int | D_int;
    pop   = state_q == RESPOND;
    entry = '{op: pick_op(H_int, E_int), index: index};
  end
  job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .data_i (entry),
    .data_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );
  // eng_start is registered on the edge that enters ISSUE (or the edge eng_busy drops),
  // so it is high for the single ISSUE cycle that precedes WAIT.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    respond = 1'b0;
    tmo     = 1'b0;
    wcnt_d  = state_q == WAIT ? wcnt_q + 1'b1 : '0;
    unique case (state_q)
      IDLE: if (!empty) begin
        state_d = ISSUE;
        launch  = !eng_busy;
      end
      ISSUE: if (start_q) state_d = WAIT;
             else launch = !eng_busy;
      WAIT: if (eng_done || wcnt_q == TMAX) begin
        state_d = RESPOND;
        respond = 1'b1;
        tmo     = !eng_done;
      end
      RESPOND: state_d = count != ONE ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
    start_d = launch;
    op_d    = launch ? head.op : op_q;
    idx_d   = launch ? head.index : idx_q;
    done_d  = respond ? {head.op == OP_HASH, head.op == OP_ENC, head.op == OP_DEC} : 3'b000;
    err_new          = 3'b000;
    err_new[ERR_OVF] = push && full && !pop;
    err_new[ERR_COL] = (H_int & E_int) | (H_int & D_int) | (E_int & D_int);
    err_new[ERR_TMO] = tmo;
    err_d = (err_clr ? 3'b000 : err_q) | err_new;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      start_q <= 1'b0;
      op_q    <= '0;
      idx_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      start_q <= start_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  assign {H_done, E_done, D_done} = done_q;
  assign eng_start = start_q;
  assign eng_op    = op_q;
  assign eng_index = idx_q;
  assign q_full    = full;
  assign err       = err_q;
endmodule

// File: tb/tb_crypto_job_ctrl.sv
// tb_crypto_job_ctrl: directed self-checking bench for crypto_job_ctrl (DEPTH=4, TIMEOUT=16)
module tb_crypto_job_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic H_int = 0, E_int = 0, D_int = 0, eng_busy = 0, eng_done = 0, err_clr = 0;
  logic [15:0] index = '0;
  logic H_done, E_done, D_done, eng_start, q_full;
  logic [1:0] eng_op;
  logic [15:0] eng_index;
  logic [2:0] err;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  crypto_job_ctrl #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .H_int(H_int), .E_int(E_int), .D_int(D_int), .index(index),
    .H_done(H_done), .E_done(E_done), .D_done(D_done), .eng_start(eng_start), .eng_op(eng_op),
    .eng_index(eng_index), .eng_busy(eng_busy), .eng_done(eng_done), .err_clr(err_clr),
    .q_full(q_full), .err(err)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Wait (bounded) for a launch, check it, complete it, check the done pulse {H,E,D}
  task automatic run_job(input string tag, input logic [1:0] op, input logic [15:0] idx, input logic [2:0] dn);
    int w = 0;
    while (!eng_start && w < 50) begin
      tick;
      w++;
    end
    chk({tag, "_start"}, 32'(eng_start), 32'd1);
    chk({tag, "_op"}, 32'(eng_op), 32'(op));
    chk({tag, "_idx"}, 32'(eng_index), 32'(idx));
    tick;
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    chk({tag, "_done"}, 32'({H_done, E_done, D_done}), 32'(dn));
  endtask
  task automatic quiet(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      tick;
      seen += int'(eng_start) + int'(H_done) + int'(E_done) + int'(D_done);
    end
    chk(tag, 32'(seen), 32'd0);
  endtask
  initial begin
    tick;
    tick;
    chk("rst_outs", 32'({H_done, E_done, D_done, eng_start, eng_op, eng_index, q_full, err}), 32'd0);
    rst_n = 1'b1;
    tick;
    // single hash job with exact latency
    H_int = 1'b1;
    index = 16'h0040;
    tick;
    H_int = 1'b0;
    index = '0;
    chk("lat_start_early", 32'(eng_start), 32'd0);
    tick;
    chk("lat_start", 32'(eng_start), 32'd1);
    chk("lat_op", 32'(eng_op), 32'd0);
    chk("lat_idx", 32'(eng_index), 32'h40);
    tick;
    chk("start_one_cycle", 32'(eng_start), 32'd0);
    tick;
    tick;
    tick;
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    chk("lat_hdone", 32'({H_done, E_done, D_done}), 32'b100);
    chk("idx_held", 32'(eng_index), 32'h40);
    tick;
    chk("hdone_pulse", 32'(H_done), 32'd0);
    chk("single_err", 32'(err), 32'd0);
    // back-to-back E, D, H
    eng_busy = 1'b1;
    E_int = 1'b1; index = 16'h0010; tick; E_int = 1'b0;
    D_int = 1'b1; index = 16'h0020; tick; D_int = 1'b0;
    H_int = 1'b1; index = 16'h0030; tick; H_int = 1'b0;
    eng_busy = 1'b0;
    run_job("b2b_e", 2'd1, 16'h0010, 3'b010);
    run_job("b2b_d", 2'd2, 16'h0020, 3'b001);
    run_job("b2b_h", 2'd0, 16'h0030, 3'b100);
    chk("b2b_err", 32'(err), 32'd0);
    quiet("b2b_drain", 4);
    // overflow
    eng_busy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      H_int = 1'b1;
      index = 16'(i);
      tick;
      if (i == 3) chk("ovf_not_full3", 32'(q_full), 32'd0);
      if (i == 4) chk("ovf_full4", 32'(q_full), 32'd1);
      if (i == 4) chk("ovf_err4", 32'(err), 32'd0);
    end
    H_int = 1'b0;
    chk("ovf_err", 32'(err), 32'b001);
    tick;
    eng_busy = 1'b0;
    run_job("ovf_1", 2'd0, 16'd1, 3'b100);
    run_job("ovf_2", 2'd0, 16'd2, 3'b100);
    run_job("ovf_3", 2'd0, 16'd3, 3'b100);
    run_job("ovf_4", 2'd0, 16'd4, 3'b100);
    quiet("ovf_dropped", 8);
    chk("ovf_unfull", 32'(q_full), 32'd0);
    err_clr = 1'b1; tick; err_clr = 1'b0;
    chk("ovf_clr", 32'(err), 32'd0);
    // collision
    H_int = 1'b1; E_int = 1'b1; index = 16'h0005; tick; H_int = 1'b0; E_int = 1'b0;
    chk("col_err", 32'(err), 32'b010);
    run_job("col_h", 2'd0, 16'h0005, 3'b100);
    quiet("col_no_e", 8);
    E_int = 1'b1; D_int = 1'b1; index = 16'h0006; err_clr = 1'b1; tick;
    E_int = 1'b0; D_int = 1'b0; err_clr = 1'b0;
    chk("col_clr_new_wins", 32'(err), 32'b010);
    run_job("col_e", 2'd1, 16'h0006, 3'b010);
    err_clr = 1'b1; tick; err_clr = 1'b0;
    chk("col_clr", 32'(err), 32'd0);
    // timeout
    E_int = 1'b1; index = 16'h0077; tick; E_int = 1'b0;
    tick;
    chk("tmo_start", 32'(eng_start), 32'd1);
    tick;
    for (int i = 0; i < 15; i++) tick;
    chk("tmo_early", 32'(E_done), 32'd0);
    chk("tmo_err_early", 32'(err), 32'd0);
    tick;
    chk("tmo_edone", 32'({H_done, E_done, D_done}), 32'b010);
    chk("tmo_err", 32'(err), 32'b100);
    tick;
    // reset during WAIT, then late eng_done
    H_int = 1'b1; index = 16'h0009; tick; H_int = 1'b0;
    tick;
    chk("rstw_start", 32'(eng_start), 32'd1);
    tick;
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_outs", 32'({H_done, E_done, D_done, eng_start, eng_op, eng_index, q_full, err}), 32'd0);
    #1 rst_n = 1'b1;
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    chk("rstw_late_done", 32'({H_done, E_done, D_done}), 32'd0);
    quiet("rstw_empty", 6);
    chk("rstw_final", 32'({eng_op, eng_index, q_full, err}), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
